ahb_init_arb: RTL

AHB_INIT_ARB -- requirements
Module: ahb_init_arb

---
 rtl/ahb_arb_pkg.sv | 34 +++
 rtl/rr_arb2.sv | 39 +++
 rtl/ahb_init_arb.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/ahb_arb_pkg.sv
// Shared encodings for the two-requester AHB initiator: bus constants,
// phase-FSM state type and the local command legality check.
package ahb_arb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // A command is refused locally when its size code is 3 or the address
    // is not naturally aligned to the access size.
    function automatic logic cmd_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [2:0] w_hsize;
        w_hsize = {1'b0, size};
        case (w_hsize)
            HSIZE_BYTE: cmd_illegal = 1'b0;
            HSIZE_HALF: cmd_illegal = addr_lo[0];
            HSIZE_WORD: cmd_illegal = |addr_lo;
            default:    cmd_illegal = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter: round-robin on the last-served pointer, or fixed
// priority (requester 0 first) when RR_EN is 0.
module rr_arb2 #(
    parameter bit RR_EN = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic       i_take,
    output logic       o_valid,
    output logic       o_gnt
);

    logic r_last;
    logic w_gnt;

    // Winner selection; under contention the requester not served last wins.
    always_comb begin
        w_gnt = 1'b0;
        if (i_req == 2'b11) begin
            w_gnt = RR_EN ? ~r_last : 1'b0;
        end else if (i_req[1]) begin
            w_gnt = 1'b1;
        end
    end

    assign o_valid = |i_req;
    assign o_gnt   = w_gnt;

    // Pointer resets to "last = 1" so requester 0 wins the first contention.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last <= 1'b1;
        end else if (i_take && o_valid) begin
            r_last <= w_gnt;
        end
    end

endmodule

// File: rtl/ahb_init_arb.sv
// Two-requester AHB-Lite initiator for the CM3 INITEXP0 port: arbitrates,
// runs one single NONSEQ transfer per grant and returns a DONE pulse.
// Handshake: a requester holds REQ with a stable command until its DONE
// pulse; DONE is high for one cycle and qualifies RDATA and ERR.
module ahb_init_arb
    import ahb_arb_pkg::*;
#(
    parameter logic [3:0] HPROT_VAL = 4'b0011,
    parameter bit         RR_EN     = 1'b1
) (
    input  logic        CLK_CM3,
    input  logic        SYS_RST,
    input  logic        REQ0,
    input  logic        REQ1,
    input  logic        WRITE0,
    input  logic        WRITE1,
    input  logic [31:0] ADDR0,
    input  logic [31:0] ADDR1,
    input  logic [1:0]  SIZE0,
    input  logic [1:0]  SIZE1,
    input  logic [31:0] WDATA0,
    input  logic [31:0] WDATA1,
    output logic        DONE0,
    output logic        DONE1,
    output logic [31:0] RDATA0,
    output logic [31:0] RDATA1,
    output logic        ERR0,
    output logic        ERR1,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic        HSEL,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    output logic [1:0]  DBG_STATE
);

    state_t      r_state;
    logic        r_gnt;
    logic        r_lerr;
    logic [31:0] r_wdata;
    logic [1:0]  r_done;
    logic [1:0]  r_err;
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;
    logic [31:0] r_haddr;
    logic [1:0]  r_htrans;
    logic        r_hwrite;
    logic [2:0]  r_hsize;
    logic [3:0]  r_hprot;
    logic        r_hsel;
    logic [31:0] r_hwdata;

    logic        w_valid;
    logic        w_gnt;
    logic        w_take;
    logic        w_write;
    logic [31:0] w_addr;
    logic [1:0]  w_size;
    logic [31:0] w_wdata;
    logic        w_lerr;

    // Grants are only taken while idle, so the pointer moves once per transfer.
    assign w_take = (r_state == ST_IDLE);

    rr_arb2 #(
        .RR_EN(RR_EN)
    ) u_arb (
        .i_clk   (CLK_CM3),
        .i_rst   (SYS_RST),
        .i_req   ({REQ1, REQ0}),
        .i_take  (w_take),
        .o_valid (w_valid),
        .o_gnt   (w_gnt)
    );

    // Select the winner's command and pre-compute its legality.
    always_comb begin
        w_write = w_gnt ? WRITE1 : WRITE0;
        w_addr  = w_gnt ? ADDR1  : ADDR0;
        w_size  = w_gnt ? SIZE1  : SIZE0;
        w_wdata = w_gnt ? WDATA1 : WDATA0;
        w_lerr  = cmd_illegal(w_size, w_addr[1:0]);
    end

    // Phase FSM with registered bus and completion outputs.
    always_ff @(posedge CLK_CM3 or posedge SYS_RST) begin
        if (SYS_RST) begin
            r_state  <= ST_IDLE;
            r_gnt    <= 1'b0;
            r_lerr   <= 1'b0;
            r_wdata  <= '0;
            r_done   <= '0;
            r_err    <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_haddr  <= '0;
            r_htrans <= HTRANS_IDLE;
            r_hwrite <= 1'b0;
            r_hsize  <= '0;
            r_hprot  <= '0;
            r_hsel   <= 1'b0;
            r_hwdata <= '0;
        end else begin
            r_done <= '0;
            r_err  <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_gnt    <= w_gnt;
                        r_lerr   <= w_lerr;
                        r_wdata  <= w_wdata;
                        r_haddr  <= w_addr;
                        r_hwrite <= w_write;
                        r_hsize  <= {1'b0, w_size};
                        if (!w_lerr) begin
                            r_htrans <= HTRANS_NONSEQ;
                            r_hsel   <= 1'b1;
                            r_hprot  <= HPROT_VAL;
                        end
                        r_state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (r_lerr) begin
                        // Refused command: report without touching the bus.
                        r_done[r_gnt] <= 1'b1;
                        r_err[r_gnt]  <= 1'b1;
                        r_state       <= ST_RESP;
                    end else if (HREADY) begin
                        r_htrans <= HTRANS_IDLE;
                        r_hsel   <= 1'b0;
                        r_hprot  <= '0;
                        r_hwdata <= r_hwrite ? r_wdata : 32'd0;
                        r_state  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (HREADY) begin
                        r_hwdata      <= '0;
                        r_done[r_gnt] <= 1'b1;
                        r_err[r_gnt]  <= HRESP;
                        if (r_gnt) begin
                            r_rdata1 <= HRDATA;
                        end else begin
                            r_rdata0 <= HRDATA;
                        end
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign DONE0     = r_done[0];
    assign DONE1     = r_done[1];
    assign ERR0      = r_err[0];
    assign ERR1      = r_err[1];
    assign RDATA0    = r_rdata0;
    assign RDATA1    = r_rdata1;
    assign HADDR     = r_haddr;
    assign HTRANS    = r_htrans;
    assign HWRITE    = r_hwrite;
    assign HSIZE     = r_hsize;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = r_hprot;
    assign HMASTLOCK = 1'b0;
    assign HSEL      = r_hsel;
    assign HWDATA    = r_hwdata;
    assign DBG_STATE = r_state;

endmodule
